axi_write_slave: RTL and testbench

AXI_WRITE_SLAVE -- requirements
Module: axi_write_slave

---
 rtl/axi_write_slave.sv | 197 +++++++++++++++++++
 tb/tb_axi_write_slave.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_slave.sv
// AXI write-channel slave with a simple one-cycle memory write port.
// One burst in flight; address sequencing for FIXED/INCR/WRAP, SLVERR on protocol or size faults.
//
// state | meaning
// IDLE  | awready high, waiting for an address handshake
// DATA  | accepting W beats whenever the memory is ready
// RESP  | holding the B response until the master takes it
module axi_write_slave #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic [AW-1:0]     axi_awaddr,
    input  logic [7:0]        axi_awlen,
    input  logic [2:0]        axi_awsize,
    input  logic [1:0]        axi_awburst,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [DW-1:0]     axi_wdata,
    input  logic [DW/8-1:0]   axi_wstrb,
    input  logic              axi_wlast,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wstrb
);

    localparam int SW     = DW / 8;
    localparam int SZ_MAX = $clog2(SW);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [2:0]      size_q, size_d;
    logic [1:0]      burst_q, burst_d;
    logic [8:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            nowr_q, nowr_d;
    logic            awready_q, awready_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic [AW-1:0]   step;
    logic [AW-1:0]   wrap_mask;
    logic [AW-1:0]   addr_next;
    logic            wrap_ok;
    logic            aw_len_ok;
    logic            aw_size_bad;
    logic            is_last;
    logic            last_bad;
    logic            w_hs;

    assign axi_wready  = (state_q == DATA) && mem_ready;
    assign axi_awready = awready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;

    assign w_hs     = axi_wready && axi_wvalid;
    assign is_last  = (cnt_q == {1'b0, len_q});
    assign last_bad = (axi_wlast != is_last);

    assign aw_len_ok   = (axi_awlen == 8'd1) || (axi_awlen == 8'd3) ||
                         (axi_awlen == 8'd7) || (axi_awlen == 8'd15);
    assign aw_size_bad = int'(axi_awsize) > SZ_MAX;
    assign wrap_ok     = (len_q == 8'd1) || (len_q == 8'd3) ||
                         (len_q == 8'd7) || (len_q == 8'd15);

    // A WRAP with an illegal length has no power-of-two window, so it steps like INCR.
    always_comb begin
        step      = AW'(1) << size_q;
        wrap_mask = (AW'({1'b0, len_q} + 9'd1) << size_q) - AW'(1);
        addr_next = addr_q + step;
        if (burst_q == 2'b00) begin
            addr_next = addr_q;
        end else if (burst_q == 2'b10 && wrap_ok) begin
            addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        nowr_d      = nowr_q;
        awready_d   = awready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        case (state_q)
            IDLE: begin
                awready_d = 1'b1;
                if (axi_awvalid && awready_q) begin
                    addr_d    = axi_awaddr;
                    len_d     = axi_awlen;
                    size_d    = axi_awsize;
                    burst_d   = axi_awburst;
                    cnt_d     = 9'd0;
                    nowr_d    = aw_size_bad;
                    err_d     = (axi_awburst == 2'b11) ||
                                (axi_awburst == 2'b10 && !aw_len_ok) ||
                                aw_size_bad;
                    awready_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    mem_we_d    = !nowr_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = axi_wdata;
                    mem_wstrb_d = axi_wstrb;
                    cnt_d       = cnt_q + 9'd1;
                    addr_d      = addr_next;
                    if (last_bad) begin
                        err_d = 1'b1;
                    end
                    if (is_last) begin
                        bvalid_d = 1'b1;
                        bresp_d  = (err_q || last_bad) ? 2'b10 : 2'b00;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                if (axi_bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = 2'b00;
                    awready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            nowr_q      <= 1'b0;
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            nowr_q      <= nowr_d;
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// Randomized and directed bench for axi_write_slave against a burst-level address/response model.
module tb_axi_write_slave;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [AW-1:0]   awaddr = '0;
    logic [7:0]      awlen = '0;
    logic [2:0]      awsize = '0;
    logic [1:0]      awburst = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [SW-1:0]   wstrb = '0;
    logic            wlast = 1'b0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic            mem_ready = 1'b0;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [SW-1:0]   mem_wstrb;

    axi_write_slave #(.AW(AW), .DW(DW)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rstn),
        .axi_awaddr  (awaddr),
        .axi_awlen   (awlen),
        .axi_awsize  (awsize),
        .axi_awburst (awburst),
        .axi_awvalid (awvalid),
        .axi_awready (awready),
        .axi_wdata   (wdata),
        .axi_wstrb   (wstrb),
        .axi_wlast   (wlast),
        .axi_wvalid  (wvalid),
        .axi_wready  (wready),
        .axi_bresp   (bresp),
        .axi_bvalid  (bvalid),
        .axi_bready  (bready),
        .mem_ready   (mem_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } wr_t;

    wr_t exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every memory write must match the next write the model predicted, in order.
    always @(negedge clk) begin
        if (rstn && mem_we) begin
            wr_t e;
            if (exp_q.size() == 0) begin
                check_val("unexpected_mem_we", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("mem_addr", mem_addr, e.a);
                check_val("mem_wdata", mem_wdata, e.d);
                check_val("mem_wstrb", mem_wstrb, e.s);
            end
        end
    end

    function automatic logic [AW-1:0] model_next(input logic [AW-1:0] a, input int len,
                                                 input int size, input int burst);
        longint step, win, base, ua;
        step = longint'(1) << size;
        ua   = longint'(a);
        if (burst == 0) return a;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            win  = longint'(len + 1) * step;
            base = ua - (ua % win);
            return AW'(base + ((ua - base + step) % win));
        end
        return AW'(ua + step);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [AW-1:0] a, input int len, input int size, input int burst);
        awaddr  = a;
        awlen   = 8'(len);
        awsize  = 3'(size);
        awburst = 2'(burst);
        awvalid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (awready) begin
                tick();
                break;
            end
            if (t > 200) begin
                check_val("aw_timeout", 1, 0);
                break;
            end
            tick();
        end
        awvalid = 1'b0;
        check_val("awready_low_after_accept", awready, 0);
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last,
                          input int rate, input logic exp_we);
        logic hs;
        wdata  = d;
        wstrb  = s;
        wlast  = last;
        wvalid = 1'b1;
        for (int t = 0; ; t++) begin
            mem_ready = ($urandom_range(0, 99) < rate);
            @(negedge clk);
            check_val("wready_eq_mem_ready", wready, mem_ready);
            hs = wready;
            tick();
            if (hs) begin
                check_val("mem_we_after_hs", mem_we, exp_we);
                break;
            end
            if (t > 300) begin
                check_val("w_timeout", 1, 0);
                break;
            end
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic wait_b(input logic exp_err, input int delay);
        int t;
        t = 0;
        mem_ready = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bvalid) break;
            if (++t > 50) begin
                check_val("b_timeout", 1, 0);
                return;
            end
        end
        check_val("bresp", bresp, exp_err ? 2'b10 : 2'b00);
        wvalid = 1'b1;
        for (int i = 0; i < delay; i++) begin
            tick();
            check_val("bvalid_held", bvalid, 1);
            check_val("bresp_held", bresp, exp_err ? 2'b10 : 2'b00);
            check_val("awready_in_resp", awready, 0);
            check_val("wready_in_resp", wready, 0);
        end
        wvalid = 1'b0;
        @(negedge clk);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_val("bvalid_dropped", bvalid, 0);
        check_val("awready_after_b", awready, 1);
        check_val("writes_outstanding", exp_q.size(), 0);
    endtask

    task automatic run_burst(input logic [AW-1:0] a, input int len, input int size, input int burst,
                             input int bad_beat, input int rate, input int bdelay);
        logic [DW-1:0] dv [0:255];
        logic [SW-1:0] sv [0:255];
        logic [AW-1:0] cur;
        logic          err;
        logic          last;
        logic          wr_ok;
        wr_t           e;
        wr_ok = (size <= $clog2(SW));
        err   = (burst == 3) || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
                || !wr_ok || (bad_beat >= 0 && bad_beat <= len);
        cur = a;
        for (int i = 0; i <= len; i++) begin
            dv[i] = {$urandom, $urandom};
            sv[i] = SW'($urandom);
            if (wr_ok) begin
                e.a = cur;
                e.d = dv[i];
                e.s = sv[i];
                exp_q.push_back(e);
            end
            cur = model_next(cur, len, size, burst);
        end
        send_aw(a, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, 2)) begin
                mem_ready = $urandom_range(0, 1);
                tick();
            end
            last = (i == len) ^ (i == bad_beat);
            send_w(dv[i], sv[i], last, rate, wr_ok);
        end
        wait_b(err, bdelay);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_awready"}, awready, 0);
        check_val({tag, "_wready"}, wready, 0);
        check_val({tag, "_bvalid"}, bvalid, 0);
        check_val({tag, "_bresp"}, bresp, 0);
        check_val({tag, "_mem_we"}, mem_we, 0);
        check_val({tag, "_mem_addr"}, mem_addr, 0);
        check_val({tag, "_mem_wdata"}, mem_wdata, 0);
        check_val({tag, "_mem_wstrb"}, mem_wstrb, 0);
    endtask

    initial begin
        int len, size, burst, bad;
        wr_t e;
        #1;
        mem_ready = 1'b1;
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        rstn = 1'b1;
        #1;
        check_val("awready_before_first_edge", awready, 0);
        tick();
        check_val("awready_first_edge", awready, 1);

        run_burst(32'h100, 0, 3, 1, -1, 100, 0);
        run_burst(32'h1C, 3, 2, 2, -1, 100, 0);
        run_burst(32'h40, 2, 2, 0, -1, 50, 0);
        run_burst(32'h80, 3, 2, 1, 1, 100, 0);
        run_burst(32'h300, 1, 3, 1, -1, 100, 10);
        run_burst(32'h200, 2, 3, 1, 2, 80, 1);
        run_burst(32'h400, 1, 1, 3, -1, 100, 0);
        run_burst(32'h500, 3, 4, 1, -1, 100, 0);
        run_burst(32'h600, 2, 2, 2, -1, 100, 0);
        run_burst(32'hFFFF_FFF8, 1, 3, 1, -1, 100, 0);
        run_burst(32'h1234_567A, 7, 1, 2, -1, 70, 0);

        // Abandon a four-beat burst after its second beat.
        for (int i = 0; i < 4; i++) begin
            e.a = 32'h200 + 32'(i * 4);
            e.d = 64'hA5A5_0000_0000_0000 | 64'(i);
            e.s = 8'h0F;
            exp_q.push_back(e);
        end
        send_aw(32'h200, 3, 2, 1);
        send_w(64'hA5A5_0000_0000_0000, 8'h0F, 1'b0, 100, 1'b1);
        send_w(64'hA5A5_0000_0000_0001, 8'h0F, 1'b0, 100, 1'b1);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midburst_rst");
        exp_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        #1;
        check_val("awready_after_midburst_release", awready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("no_b_after_abandon", bvalid, 0);
            check_val("no_we_after_abandon", mem_we, 0);
        end
        check_val("awready_after_recovery", awready, 1);
        run_burst(32'h700, 3, 2, 1, -1, 100, 0);

        for (int n = 0; n < 40; n++) begin
            burst = $urandom_range(0, 9);
            burst = (burst < 3) ? 1 : (burst < 5) ? 0 : (burst < 9) ? 2 : 3;
            if (burst == 2) begin
                len = $urandom_range(0, 3);
                len = (len == 0) ? 1 : (len == 1) ? 3 : (len == 2) ? 7 : 15;
            end else begin
                len = $urandom_range(0, 15);
            end
            size = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            bad  = ($urandom_range(0, 6) == 0) ? $urandom_range(0, len) : -1;
            run_burst(32'($urandom), len, size, burst, bad, $urandom_range(30, 100),
                      $urandom_range(0, 3));
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
